input_route_ctrl: RTL and testbench
===================================

# input_route_ctrl

Input-port route controller that sits directly downstream of one input-port synchronous FIFO in the router. It drains flits from the FIFO into a 2-entry staging queue and decodes each head flit's destination with XY routing. It then requests the matching output port from the switch allocator, and once granted streams the packet's flits to the crossbar until the tail flit. The grant is released on the tail handshake.

## Interface
Parameters:
- WIDTH, 32, flit width in bits; must equal the upstream FIFO WIDTH
- X_W, 2, destination X field width
- Y_W, 2, destination Y field width
- CUR_X, 0, this router's X coordinate
- CUR_Y, 0, this router's Y coordinate

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- FIFO_EMPTY  in  1  upstream FIFO empty
- FIFO_DATA  in  WIDTH  upstream FIFO read data; valid the cycle after FIFO_RD_EN
- FIFO_RD_EN  out  1  upstream FIFO read enable
- REQ_VLD  out  1  switch-allocation request
- REQ_PORT  out  5  one-hot requested port: [0]LOCAL [1]NORTH [2]EAST [3]SOUTH [4]WEST
- GNT  in  1  allocator grant for REQ_PORT
- OUT_VALID  out  1  crossbar flit valid
- OUT_DATA  out  WIDTH  crossbar flit
- OUT_READY  in  1  crossbar accepts flit
- RELEASE  out  1  one-cycle pulse: packet done, allocator frees the port
- ERR_CNT  out  8  saturating count of dropped stray flits

## Operation
- Flit format:
  - type = [WIDTH-1:WIDTH-2]: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE (head+tail).
  - dest X = next X_W bits below type; dest Y = next Y_W bits below dest X.
- Staging queue: 2 entries, FIFO order; occ = 0..2.
  - rd_pend = FIFO_RD_EN was asserted in the previous cycle.
  - pop = the head entry is removed this cycle.
- Read rule: FIFO_RD_EN = !FIFO_EMPTY && (occ + rd_pend − pop ≤ 1).
  - Returned data is written to the queue tail at the end of its arrival cycle.
  - The queue never overflows.
  - Reads continue past a tail flit; the next packet's head waits in the queue.
- Route compute, unsigned compares:
  - dx > CUR_X → EAST; dx < CUR_X → WEST.
  - else dy > CUR_Y → NORTH; dy < CUR_Y → SOUTH.
  - else LOCAL.
- FSM states IDLE, REQ, XFER.
  - IDLE, queue head is HEAD or SINGLE: register its route into REQ_PORT → REQ. The head flit is not popped.
  - IDLE, queue head is BODY or TAIL: pop it (drop), ERR_CNT += 1 saturating at 255, stay in IDLE.
  - IDLE, queue empty: stay.
  - REQ: REQ_VLD=1 with REQ_PORT stable until GNT=1. On GNT → XFER; REQ_VLD=0 from the next cycle.
  - XFER: OUT_VALID = queue non-empty; OUT_DATA = queue head. Pop when OUT_VALID && OUT_READY.
  - XFER, popped flit is TAIL or SINGLE: RELEASE=1 in that same cycle → IDLE; REQ_PORT cleared to 0.
- OUT_VALID=0 and REQ_VLD=0 outside XFER and REQ respectively.
- Flit order is preserved. No flit is duplicated or lost except stray BODY/TAIL flits dropped in IDLE.

## Timing
- Reset, asynchronous:
  - FSM → IDLE; occ=0; rd_pend=0.
  - FIFO_RD_EN=0, REQ_VLD=0, REQ_PORT=0, OUT_VALID=0, OUT_DATA=0, RELEASE=0, ERR_CNT=0.
  - Data returned after reset for a read issued before reset is discarded.
- Outputs are combinational from registered state:
  - FIFO_RD_EN depends on FIFO_EMPTY and, via pop, on OUT_READY.
  - OUT_VALID and OUT_DATA are driven from the queue.
- Latency, empty router with GNT held high:
  - cycle 0 FIFO_RD_EN → cycle 1 data arrives → cycle 2 IDLE sees head, route registered → cycle 3 REQ_VLD=1 and GNT → cycle 4 first flit OUT_VALID.
- Throughput in XFER with OUT_READY=1: one flit per cycle sustained (occ=1, rd_pend=1, pop=1 steady state).
- GNT is ignored outside REQ.
- OUT_READY is ignored when OUT_VALID=0.
- Single-flit packet: RELEASE on the same cycle as its only handshake.

## Test plan
- Route decode, with CUR=(1,1): SINGLE flits to (1,1), (1,2), (2,1), (1,0), (0,1) → REQ_PORT = 00001, 00010, 00100, 01000, 10000. Each flit forwarded once after GNT; RELEASE coincides with its handshake.
- 4-flit packet to (3,1), GNT and OUT_READY tied high → REQ_PORT=00100; the 4 flits appear on 4 consecutive cycles in order; RELEASE on the 4th; FSM returns to IDLE.
- Back-to-back packets in the FIFO (HEAD,BODY,TAIL to EAST, then HEAD,TAIL to WEST) → the second head is not output until a new REQ_PORT=10000 is granted; all 5 flits out in order, none duplicated.
- Random OUT_READY (50%) during a 16-flit packet → occ never exceeds 2; FIFO_RD_EN never asserted while FIFO_EMPTY; output sequence matches input.
- Stray flits: 3 BODY flits in IDLE → dropped, ERR_CNT=3. 300 strays → ERR_CNT saturates at 255.
- RST asserted mid-XFER with rd_pend=1 → all outputs 0 immediately. After release, the old returned data does not appear, and the next HEAD in the FIFO is routed normally.

Source files
------------

// File: rtl/input_route_ctrl.sv
// ---------------------------------------------------------------------------
// input_route_ctrl
//
// Per-input-port route controller. Drains flits from the upstream synchronous
// FIFO into a 2-entry staging queue, XY-routes each packet's head flit,
// requests the resulting output port from the switch allocator and, once
// granted, streams the packet to the crossbar up to and including its tail.
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   FIFO_EMPTY    upstream FIFO empty
//   FIFO_DATA     upstream FIFO read data (valid the cycle after FIFO_RD_EN)
//   FIFO_RD_EN    upstream FIFO read enable
//   REQ_VLD       switch-allocation request
//   REQ_PORT      one-hot port: [0]LOCAL [1]NORTH [2]EAST [3]SOUTH [4]WEST
//   GNT           allocator grant for REQ_PORT
//   OUT_VALID     crossbar flit valid
//   OUT_DATA      crossbar flit
//   OUT_READY     crossbar accepts flit
//   RELEASE       one-cycle pulse on the packet's last handshake
//   ERR_CNT       saturating count of stray BODY/TAIL flits dropped in IDLE
// ---------------------------------------------------------------------------
module input_route_ctrl #(
  parameter int WIDTH = 32,
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_EMPTY,
  input  logic [WIDTH-1:0] FIFO_DATA,
  output logic             FIFO_RD_EN,
  output logic             REQ_VLD,
  output logic [4:0]       REQ_PORT,
  input  logic             GNT,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  input  logic             OUT_READY,
  output logic             RELEASE,
  output logic [7:0]       ERR_CNT
);

  localparam logic [X_W-1:0] CUR_X_V = X_W'(CUR_X);
  localparam logic [Y_W-1:0] CUR_Y_V = Y_W'(CUR_Y);

  localparam logic [4:0] PORT_LOCAL = 5'b00001;
  localparam logic [4:0] PORT_NORTH = 5'b00010;
  localparam logic [4:0] PORT_EAST  = 5'b00100;
  localparam logic [4:0] PORT_SOUTH = 5'b01000;
  localparam logic [4:0] PORT_WEST  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg [2];
  logic [WIDTH-1:0] q_next [2];
  logic [1:0]       occ_reg, occ_next;
  logic             rd_pend_reg;
  logic [4:0]       req_port_reg;
  logic [7:0]       err_cnt_reg;

  logic [WIDTH-1:0] head;
  logic [1:0]       head_type;
  logic             head_vld;
  logic             head_is_hdr;
  logic             head_is_last;
  logic [X_W-1:0]   dest_x;
  logic [Y_W-1:0]   dest_y;
  logic [X_W:0]     diff_x;
  logic [Y_W:0]     diff_y;
  logic [4:0]       route;

  logic             drop;
  logic             pop;
  logic             push;
  logic             wr_idx;
  logic [2:0]       fill_after;

  // -------------------------------------------------------------------------
  // Head-of-queue decode
  // -------------------------------------------------------------------------
  assign head      = q_reg[0];
  assign head_type = head[WIDTH-1 -: 2];
  assign head_vld  = (occ_reg != 2'd0);
  // Type encoding: BODY 00, HEAD 01, TAIL 10, SINGLE 11. Bit 0 marks a packet
  // start, bit 1 marks a packet end.
  assign head_is_hdr  = head_type[0];
  assign head_is_last = head_type[1];
  assign dest_x = head[WIDTH-3 -: X_W];
  assign dest_y = head[WIDTH-3-X_W -: Y_W];

  // Unsigned compares via a one-bit-wider subtract: the top bit is the borrow
  // (dest < current). Keeps the logic free of constant comparisons when the
  // router sits at coordinate 0.
  assign diff_x = {1'b0, dest_x} - {1'b0, CUR_X_V};
  assign diff_y = {1'b0, dest_y} - {1'b0, CUR_Y_V};

  always_comb begin
    route = PORT_LOCAL;
    if (diff_x[X_W]) begin
      route = PORT_WEST;
    end else if (dest_x != CUR_X_V) begin
      route = PORT_EAST;
    end else if (diff_y[Y_W]) begin
      route = PORT_SOUTH;
    end else if (dest_y != CUR_Y_V) begin
      route = PORT_NORTH;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (head_vld && head_is_hdr) state_next = ST_REQ;
      ST_REQ:  if (GNT) state_next = ST_XFER;
      ST_XFER: if (head_vld && OUT_READY && head_is_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (plus the pop/drop strobes they imply)
  // -------------------------------------------------------------------------
  always_comb begin
    REQ_VLD   = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    RELEASE   = 1'b0;
    drop      = 1'b0;
    pop       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Stray BODY/TAIL at the head outside a packet is discarded.
        drop = head_vld && !head_is_hdr;
        pop  = drop;
      end
      ST_REQ: begin
        REQ_VLD = 1'b1;
      end
      ST_XFER: begin
        OUT_VALID = head_vld;
        OUT_DATA  = head_vld ? head : '0;
        pop       = head_vld && OUT_READY;
        RELEASE   = head_vld && OUT_READY && head_is_last;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Upstream read control
  // -------------------------------------------------------------------------
  // Occupancy the queue will hold once this cycle's pop and in-flight read
  // have settled; a new read is only issued if it is guaranteed a slot.
  // RST gates the enable so no read escapes while reset is held.
  assign fill_after = {1'b0, occ_reg} + {2'b00, rd_pend_reg} - {2'b00, pop};
  assign FIFO_RD_EN = !RST && !FIFO_EMPTY && (fill_after <= 3'd1);

  // -------------------------------------------------------------------------
  // Staging queue (entry 0 is the head)
  // -------------------------------------------------------------------------
  assign push = rd_pend_reg;
  // A push only ever happens with occ <= 1, so the tail slot after the pop is
  // occ - pop, which fits in one bit.
  assign wr_idx   = occ_reg[0] && !pop;
  assign occ_next = occ_reg + {1'b0, push} - {1'b0, pop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    if (gi == 0) begin : g_head
      assign q_next[gi] = (push && wr_idx == 1'(gi)) ? FIFO_DATA :
                          pop                        ? q_reg[1]  : q_reg[gi];
    end else begin : g_tail
      assign q_next[gi] = (push && wr_idx == 1'(gi)) ? FIFO_DATA : q_reg[gi];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) q_reg[i] <= '0;
      occ_reg     <= 2'd0;
      rd_pend_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) q_reg[i] <= q_next[i];
      occ_reg     <= occ_next;
      rd_pend_reg <= FIFO_RD_EN;
    end
  end

  // -------------------------------------------------------------------------
  // Requested port and stray-flit counter
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_port_reg <= 5'd0;
    end else if (state_reg == ST_IDLE && head_vld && head_is_hdr) begin
      req_port_reg <= route;
    end else if (RELEASE) begin
      req_port_reg <= 5'd0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_reg <= 8'd0;
    end else if (drop && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign REQ_PORT = req_port_reg;
  assign ERR_CNT  = err_cnt_reg;

endmodule

// File: tb/tb_input_route_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_route_ctrl
//
// Randomized bench for input_route_ctrl with CUR=(1,1). A behavioural FIFO
// feeds the DUT; every flit the DUT actually receives is pushed through a
// packet-level reference model (stray drop / packet framing / XY route) that
// yields the expected grant ports, output flit order and stray count.
// ---------------------------------------------------------------------------
module tb_input_route_ctrl;

  localparam int W  = 32;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int CX = 1;
  localparam int CY = 1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         FIFO_EMPTY = 1'b0;
  logic [W-1:0] FIFO_DATA = '0;
  logic         FIFO_RD_EN;
  logic         REQ_VLD;
  logic [4:0]   REQ_PORT;
  logic         GNT = 1'b0;
  logic         OUT_VALID;
  logic [W-1:0] OUT_DATA;
  logic         OUT_READY = 1'b0;
  logic         RELEASE;
  logic [7:0]   ERR_CNT;

  always #5 CLK = ~CLK;

  input_route_ctrl #(
    .WIDTH(W), .X_W(XW), .Y_W(YW), .CUR_X(CX), .CUR_Y(CY)
  ) dut (
    .CLK(CLK), .RST(RST),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_RD_EN(FIFO_RD_EN),
    .REQ_VLD(REQ_VLD), .REQ_PORT(REQ_PORT), .GNT(GNT),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .RELEASE(RELEASE), .ERR_CNT(ERR_CNT)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_flits[$];
  logic [4:0]   exp_route[$];
  bit           pend = 0;
  logic [W-1:0] pend_val = '0;
  bit           granted = 0;
  bit           in_pkt = 0;
  int           err = 0;
  int           gnt_prob = 100;
  int           rdy_prob = 100;
  int           feed_prob = 100;
  int           cyc = 0;
  int           first_rd = -1;
  int           first_req = -1;
  int           first_out = -1;
  int           hs_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  // XY route from the destination coordinates, plain integer compares.
  function automatic logic [4:0] ref_route(int dx, int dy);
    if (dx > CX) return 5'b00100;
    if (dx < CX) return 5'b10000;
    if (dy > CY) return 5'b00010;
    if (dy < CY) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [W-1:0] mk(logic [1:0] t, int dx, int dy);
    logic [W-1:0] f;
    f = W'($urandom);
    f[W-1 -: 2]       = t;
    f[W-3 -: XW]      = XW'(dx);
    f[W-3-XW -: YW]   = YW'(dy);
    return f;
  endfunction

  // Packet-level model of what the DUT must do with each received flit.
  function automatic void model_accept(logic [W-1:0] f);
    logic [1:0] t;
    t = f[W-1 -: 2];
    if (!in_pkt) begin
      if (t == T_BODY || t == T_TAIL) begin
        err++;
      end else begin
        exp_route.push_back(ref_route(int'(f[W-3 -: XW]), int'(f[W-3-XW -: YW])));
        exp_flits.push_back(f);
        in_pkt = (t == T_HEAD);
      end
    end else begin
      exp_flits.push_back(f);
      if (t == T_TAIL || t == T_SINGLE) in_pkt = 0;
    end
  endfunction

  task automatic push_pkt(input int len, input int dx, input int dy, input bit direct);
    logic [W-1:0] f;
    for (int i = 0; i < len; i++) begin
      if (len == 1)          f = mk(T_SINGLE, dx, dy);
      else if (i == 0)       f = mk(T_HEAD, dx, dy);
      else if (i == len - 1) f = mk(T_TAIL, dx, dy);
      else                   f = mk(T_BODY, dx, dy);
      if (direct) fifo_q.push_back(f);
      else        src_q.push_back(f);
    end
  endtask

  task automatic cycle(input bit do_rst);
    bit           hs;
    bit           last;
    logic [1:0]   et;
    logic [W-1:0] exp;
    @(negedge CLK);
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_DATA  = pend ? pend_val : W'($urandom);
    GNT        = ($urandom_range(99) < gnt_prob);
    OUT_READY  = ($urandom_range(99) < rdy_prob);
    if (do_rst) begin
      RST = 1'b1;
      #1;
      check_eq("rst_rd_en", FIFO_RD_EN, 0);
      check_eq("rst_req_vld", REQ_VLD, 0);
      check_eq("rst_req_port", REQ_PORT, 0);
      check_eq("rst_out_valid", OUT_VALID, 0);
      check_eq("rst_out_data", OUT_DATA, 0);
      check_eq("rst_release", RELEASE, 0);
      check_eq("rst_err_cnt", ERR_CNT, 0);
      RST = 1'b0;
      // The read in flight is lost with the reset.
      pend = 0; in_pkt = 0; granted = 0; err = 0;
      exp_flits.delete();
      exp_route.delete();
    end
    #1;
    if (FIFO_RD_EN && first_rd < 0) first_rd = cyc;
    if (REQ_VLD && first_req < 0)    first_req = cyc;
    if (OUT_VALID && first_out < 0)  first_out = cyc;
    if (FIFO_EMPTY) check_eq("rd_on_empty", FIFO_RD_EN, 0);
    if (OUT_VALID) check_eq("vld_wo_grant", granted, 1);
    hs = OUT_VALID && OUT_READY;
    last = 0;
    if (hs) begin
      hs_cyc.push_back(cyc);
      $display("cyc %0d flit out %08h", cyc, OUT_DATA);
      if (exp_flits.size() == 0) begin
        check_eq("extra_flit", OUT_VALID, 0);
      end else begin
        exp = exp_flits.pop_front();
        check_eq("out_data", OUT_DATA, exp);
        et = exp[W-1 -: 2];
        last = (et == T_TAIL || et == T_SINGLE);
      end
    end
    check_eq("release", RELEASE, last);
    if (REQ_VLD) begin
      if (exp_route.size() == 0) begin
        check_eq("stray_req", REQ_VLD, 0);
      end else begin
        check_eq("req_port", REQ_PORT, exp_route[0]);
        if (GNT) begin
          $display("cyc %0d grant port %05b", cyc, REQ_PORT);
          void'(exp_route.pop_front());
          granted = 1;
        end
      end
    end else if (!granted) begin
      check_eq("port_idle", REQ_PORT, 0);
    end
    if (last) granted = 0;
    if (pend) begin
      model_accept(pend_val);
      pend = 0;
    end
    if (FIFO_RD_EN && fifo_q.size() > 0) begin
      pend = 1;
      pend_val = fifo_q.pop_front();
    end
    if (src_q.size() > 0 && $urandom_range(99) < feed_prob) fifo_q.push_back(src_q.pop_front());
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < max_cyc) begin
      cycle(0);
      n++;
      done = (fifo_q.size() == 0 && src_q.size() == 0 && !pend &&
              exp_flits.size() == 0 && exp_route.size() == 0);
    end
    check_eq("drain_done", done, 1);
    repeat (4) cycle(0);
  endtask

  task automatic check_err(input string tag);
    check_eq(tag, ERR_CNT, (err > 255) ? 255 : err);
  endtask

  initial begin
    int n;
    // Reset state, with a non-empty FIFO to exercise read gating.
    @(negedge CLK);
    check_eq("init_rd_en", FIFO_RD_EN, 0);
    check_eq("init_req_vld", REQ_VLD, 0);
    check_eq("init_req_port", REQ_PORT, 0);
    check_eq("init_out_valid", OUT_VALID, 0);
    check_eq("init_out_data", OUT_DATA, 0);
    check_eq("init_release", RELEASE, 0);
    check_eq("init_err_cnt", ERR_CNT, 0);
    FIFO_EMPTY = 1'b1;
    RST = 1'b0;

    // Latency from first read to request and first flit.
    gnt_prob = 100; rdy_prob = 100; feed_prob = 100;
    push_pkt(1, 2, 1, 1);
    first_rd = -1; first_req = -1; first_out = -1;
    drain(100);
    check_eq("lat_req", first_req - first_rd, 3);
    check_eq("lat_out", first_out - first_rd, 4);

    // Route decode of single-flit packets.
    gnt_prob = 50; rdy_prob = 50;
    push_pkt(1, 1, 1, 1);
    push_pkt(1, 1, 2, 1);
    push_pkt(1, 2, 1, 1);
    push_pkt(1, 1, 0, 1);
    push_pkt(1, 0, 1, 1);
    drain(300);

    // 4-flit packet at full throughput.
    gnt_prob = 100; rdy_prob = 100;
    push_pkt(4, 3, 1, 1);
    hs_cyc.delete();
    drain(100);
    check_eq("tput_n", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check_eq("tput_span", hs_cyc[3] - hs_cyc[0], 3);

    // Back-to-back packets already queued in the FIFO.
    gnt_prob = 40; rdy_prob = 100;
    push_pkt(3, 3, 0, 1);
    push_pkt(2, 0, 2, 1);
    drain(300);

    // Long packet under random backpressure with a trickling FIFO.
    gnt_prob = 100; rdy_prob = 50; feed_prob = 70;
    push_pkt(16, 2, 3, 0);
    drain(500);

    // Three stray BODY flits in IDLE.
    rdy_prob = 100; feed_prob = 100;
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk(T_BODY, 0, 0));
    drain(100);
    check_eq("stray3", ERR_CNT, 3);

    // Random packet mix with occasional strays.
    gnt_prob = 60; rdy_prob = 60; feed_prob = 60;
    for (int p = 0; p < 20; p++) begin
      if ($urandom_range(4) == 0) src_q.push_back(mk($urandom_range(1) ? T_TAIL : T_BODY, 0, 0));
      push_pkt($urandom_range(1, 6), $urandom_range(3), $urandom_range(3), 0);
    end
    drain(3000);
    check_err("err_random");

    // Counter saturation.
    gnt_prob = 100; rdy_prob = 100; feed_prob = 100;
    for (int i = 0; i < 300; i++) fifo_q.push_back(mk($urandom_range(1) ? T_TAIL : T_BODY, 0, 0));
    drain(1000);
    check_eq("err_sat", ERR_CNT, 255);

    // Reset in the middle of a transfer with a read in flight.
    push_pkt(6, 0, 0, 1);
    n = 0;
    while (!(granted && pend && fifo_q.size() >= 2) && n < 50) begin
      cycle(0);
      n++;
    end
    check_eq("rst_setup", n < 50, 1);
    cycle(1);
    push_pkt(3, 1, 3, 1);
    drain(200);
    check_err("err_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
